// File: rtl/shift_pkg.sv
// Shared constants and types for the shifter arbiter: widths, shift opcodes,
// FSM state encoding and requester identifiers.
package shift_pkg;

  localparam int DATA_W = 32;
  localparam int NUM_W  = 8;

  // Shift opcodes. The arbiter never interprets these; the shifter does.
  localparam logic [2:0] LSL_IMM = 3'b000;
  localparam logic [2:0] LSL_REG = 3'b001;
  localparam logic [2:0] LSR_IMM = 3'b010;
  localparam logic [2:0] LSR_REG = 3'b011;
  localparam logic [2:0] ASR_IMM = 3'b100;
  localparam logic [2:0] ASR_REG = 3'b101;
  localparam logic [2:0] ROR_IMM = 3'b110; // RRX when the amount is zero
  localparam logic [2:0] ROR_REG = 3'b111;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Requester identity; bit value matches the grant vector index.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // Map a one-hot grant vector to the requester it selects.
  function automatic req_id_e grant_to_id(input logic [1:0] grant);
    return grant[1] ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Grants are combinational from the request
// vector; the last winner is remembered only when the caller commits a grant.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] grant_o
);
  import shift_pkg::*;

  req_id_e last_grant_q, last_grant_d;

  // Pick a winner: a lone request wins, contention goes to the port not served last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_o      = 2'b00;
    last_grant_d = last_grant_q;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_grant_q == REQ_B) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
    if (update_i && (grant_o != 2'b00)) begin
      last_grant_d = grant_to_id(grant_o);
    end
  end

  // Remember the most recent winner; B after reset so A wins first contention.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      last_grant_q <= REQ_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // A grant vector is never anything but zero or one-hot.
  grant_onehot_a: assert property (@(posedge clock) disable iff (reset) $onehot0(grant_o));

endmodule

// File: rtl/shift_arbiter.sv
// Shares one external barrel shifter between two requesters. A request is
// accepted in IDLE, its operands drive the shifter from a register in SHIFT,
// the result is captured and held in RESP until the owner takes it.
module shift_arbiter #(
  parameter int DATA_W = shift_pkg::DATA_W,
  parameter int NUM_W  = shift_pkg::NUM_W
) (
  input  logic              clock,
  input  logic              reset,
  // Requester A
  input  logic              io_A_req_valid,
  output logic              io_A_req_ready,
  input  logic [2:0]        io_A_Shift_OP,
  input  logic [DATA_W-1:0] io_A_Shift_Data,
  input  logic [NUM_W-1:0]  io_A_Shift_Num,
  input  logic              io_A_Carry_Flag,
  output logic              io_A_resp_valid,
  input  logic              io_A_resp_ready,
  output logic [DATA_W-1:0] io_A_Shift_Out,
  output logic              io_A_Shift_Carry_Out,
  // Requester B
  input  logic              io_B_req_valid,
  output logic              io_B_req_ready,
  input  logic [2:0]        io_B_Shift_OP,
  input  logic [DATA_W-1:0] io_B_Shift_Data,
  input  logic [NUM_W-1:0]  io_B_Shift_Num,
  input  logic              io_B_Carry_Flag,
  output logic              io_B_resp_valid,
  input  logic              io_B_resp_ready,
  output logic [DATA_W-1:0] io_B_Shift_Out,
  output logic              io_B_Shift_Carry_Out,
  // Shared shifter
  output logic [2:0]        io_BS_Shift_OP,
  output logic [DATA_W-1:0] io_BS_Shift_Data,
  output logic [NUM_W-1:0]  io_BS_Shift_Num,
  output logic              io_BS_Carry_Flag,
  input  logic [DATA_W-1:0] io_BS_Shift_Out,
  input  logic              io_BS_Shift_Carry_Out
);
  import shift_pkg::*;

  state_e            state_q, state_d;
  req_id_e           owner_q, owner_d;

  // Operand register: feeds the shifter for the whole transaction.
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [NUM_W-1:0]  num_q, num_d;
  logic              carry_q, carry_d;

  // Result register: holds the shifter output while the owner is stalled.
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_carry_q, res_carry_d;

  logic [1:0]        arb_req;
  logic [1:0]        grant;
  logic              accept;
  logic              owner_resp_ready;

  // Requests only compete while idle and out of reset; ready is the grant itself.
  assign arb_req = {io_B_req_valid, io_A_req_valid} & {2{(state_q == ST_IDLE) && !reset}};
  assign accept  = |grant;

  rr_arbiter2 u_arb (
    .clock    (clock),
    .reset    (reset),
    .req_i    (arb_req),
    .update_i (accept),
    .grant_o  (grant)
  );

  assign io_A_req_ready = grant[0];
  assign io_B_req_ready = grant[1];

  assign owner_resp_ready = (owner_q == REQ_A) ? io_A_resp_ready : io_B_resp_ready;

  // Next-state and register-load logic for the IDLE -> SHIFT -> RESP sequence.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    op_d        = op_q;
    data_d      = data_q;
    num_d       = num_q;
    carry_d     = carry_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = grant_to_id(grant);
          if (grant[1]) begin
            op_d    = io_B_Shift_OP;
            data_d  = io_B_Shift_Data;
            num_d   = io_B_Shift_Num;
            carry_d = io_B_Carry_Flag;
          end else begin
            op_d    = io_A_Shift_OP;
            data_d  = io_A_Shift_Data;
            num_d   = io_A_Shift_Num;
            carry_d = io_A_Carry_Flag;
          end
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        res_data_d  = io_BS_Shift_Out;
        res_carry_d = io_BS_Shift_Carry_Out;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (owner_resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, owner, operand and result registers; reset aborts any transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= REQ_A;
      op_q        <= '0;
      data_q      <= '0;
      num_q       <= '0;
      carry_q     <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      op_q        <= op_d;
      data_q      <= data_d;
      num_q       <= num_d;
      carry_q     <= carry_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
    end
  end

  // The shifter always sees the operand register, so it is stable in every state.
  assign io_BS_Shift_OP   = op_q;
  assign io_BS_Shift_Data = data_q;
  assign io_BS_Shift_Num  = num_q;
  assign io_BS_Carry_Flag = carry_q;

  // Only the owner sees resp_valid; payload is qualified by it.
  assign io_A_resp_valid      = (state_q == ST_RESP) && (owner_q == REQ_A);
  assign io_B_resp_valid      = (state_q == ST_RESP) && (owner_q == REQ_B);
  assign io_A_Shift_Out       = res_data_q;
  assign io_A_Shift_Carry_Out = res_carry_q;
  assign io_B_Shift_Out       = res_data_q;
  assign io_B_Shift_Carry_Out = res_carry_q;

  // Both requesters are never offered ready together.
  ready_exclusive_a: assert property (@(posedge clock) disable iff (reset)
    !(io_A_req_ready && io_B_req_ready));

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Two-requester arbiter and sequencer for the shared BarrelShifter. It lets the data-processing operand-2 path (port A) and the load/store scaled-offset path (port B) share one shifter instance. Requests are accepted with valid/ready handshakes and granted round-robin. The shifter is driven from a registered operand set, and each result is returned on the requester's own response channel.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- NUM_W, 8, shift-amount width (Rs[7:0])

Ports (X ∈ {A, B}, one copy per requester):
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- io_X_req_valid  in  1  request present
- io_X_req_ready  out  1  request accepted this cycle when high with valid
- io_X_Shift_OP  in  3  shift opcode, passed through unchanged
- io_X_Shift_Data  in  DATA_W  operand
- io_X_Shift_Num  in  NUM_W  shift amount
- io_X_Carry_Flag  in  1  current C flag
- io_X_resp_valid  out  1  result available
- io_X_resp_ready  in  1  requester consumes result
- io_X_Shift_Out  out  DATA_W  result
- io_X_Shift_Carry_Out  out  1  carry result
- io_BS_Shift_OP / io_BS_Shift_Data / io_BS_Shift_Num / io_BS_Carry_Flag  out  3/DATA_W/NUM_W/1  drive to shifter
- io_BS_Shift_Out / io_BS_Shift_Carry_Out  in  DATA_W/1  from shifter (combinational)

## Operation
- FSM states: IDLE, SHIFT, RESP.
- IDLE:
  - req_ready is high only for the winner among asserted valids.
  - Round-robin: if both valids are high, grant the port not granted last; a single valid wins outright.
  - `last_grant` resets to B, so A wins the first contention.
  - On handshake: latch op/data/num/carry and the owner into the operand register, update `last_grant`, go to SHIFT.
- SHIFT:
  - io_BS_* are driven from the operand register.
  - At the clock edge, capture io_BS_Shift_Out and io_BS_Shift_Carry_Out into the result register and go to RESP.
- RESP:
  - The owner's resp_valid is high with the result register on its Shift_Out/Shift_Carry_Out.
  - Hold until the owner's resp_ready, then return to IDLE.
  - The non-owner's resp_valid stays low.
- Opcodes, amounts ≥ 32 and RRX are not interpreted; they pass through to the shifter.
- In IDLE and RESP, io_BS_* keep the last operand-register values.

## Timing
- Reset values:
  - state = IDLE, last_grant = B.
  - Operand and result registers = 0.
  - All req_ready and resp_valid = 0 during reset.
  - All Shift_Out/Carry_Out and io_BS_* = 0.
- Latency: handshake at edge k; capture at edge k+1; resp_valid high from edge k+1 until the handshake edge.
- Minimum period is 3 cycles per transaction (IDLE, SHIFT, RESP) when resp_ready is already high.
- req_ready depends combinationally on both req_valids and state; it never depends on resp_ready.
- Valid-before-ready: a requester holds valid and payload stable until ready. Dropping valid before handshake is illegal.
- resp_valid and payload stay stable while resp_ready is low.
- The next request is accepted no earlier than the cycle after the RESP handshake. There is no same-cycle turnaround.
- Simultaneous A and B valid in IDLE: exactly one req_ready is asserted, never both.
- Reset mid-transaction (SHIFT or RESP): abort; no response is ever delivered and the owner must reissue.

## Structure
- Package `shift_pkg`:
  - DATA_W, NUM_W.
  - Opcode constants: LSL_IMM=000, LSL_REG=001, LSR_IMM=010, LSR_REG=011, ASR_IMM=100, ASR_REG=101, ROR_IMM=110 (RRX when num=0), ROR_REG=111.
  - FSM state enum.
  - Requester id enum (REQ_A, REQ_B).
- Sub-module `rr_arbiter2`: a 2-way round-robin grant with `last_grant` register, an update-enable input and one-hot grant outputs.
- The top level holds the FSM, operand/result registers and channel muxing. The BarrelShifter is instantiated outside and connected via io_BS_*.

## Test plan
- Single A request, LSL_REG, data 0x12345678, num 4, C=0, resp_ready=1:
  - io_BS_* match the request in SHIFT.
  - A resp_valid goes high one edge after the accept edge, with Shift_Out=0x23456780 and carry=1.
  - B resp_valid stays 0.
- A and B valid simultaneously, held for 4 transactions each:
  - Grants alternate A, B, A, B… starting with A after reset.
  - req_ready is never high on both ports in the same cycle.
- Backpressure on B, ASR_REG on 0x80000000 by 4, resp_ready=0 for 5 cycles:
  - resp_valid stays high with 0xF8000000 held stable.
  - A req_ready stays 0 throughout.
  - Release resp_ready → IDLE next cycle.
- ROR_IMM num 0 (RRX), data 0x00000001, C=1:
  - Passed through unchanged.
  - Response is 0x80000000 with carry=1.
- Reset asserted during SHIFT, then released:
  - All outputs are 0.
  - No resp_valid appears.
  - The next contention is granted to A.
- Invalid-to-valid churn: B valid only:
  - B is accepted in 1 cycle.
  - A asserted in the same cycle as B's RESP handshake is accepted the following cycle.
